uart_rx_core: RTL

Parametrised UART receiver replacing the fixed-format serial receive path. It oversamples the line and votes each bit by majority. It supports 5–9 data bits, none/odd/even parity and one or two stop bits. Received words go out through a one-deep valid/ready holding register with per-frame error flags. It sits between the pad-side serial input and the byte-consuming logic, and reuses the codebase's 2-bit parity encoding.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_tick.sv | 42 ++++
 rtl/uart_rx_core.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, receiver FSM states and
// rx_err bit positions. The transmit side uses the same encodings.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int ERR_PARITY = 0;
    localparam int ERR_GLITCH = 1;
    localparam int ERR_FRAME  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRK
    } rx_state_e;

    // 2-of-3 majority vote used for bit decisions.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: counts 0..div and emits a registered one-clock
// tick on each wrap. clr restarts the count so ticks land at
// clr_edge + (div+1)*k.
module uart_rx_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count and wrap detection.
    always_comb begin
        cnt_d  = cnt_q + DIV_W'(1);
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == div) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority-voted bits, optional parity,
// one or two stop bits and a one-deep valid/ready holding register.
// Optional break detection is enabled with UART_RX_BREAK_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a synchronised falling edge
// ST_START  | checking the start bit (1 = glitch, abort)
// ST_DATA   | shifting DATA_W bits, LSB first
// ST_PARITY | checking the parity bit
// ST_STOP1  | first stop bit (frame ends here unless stop2)
// ST_STOP2  | second stop bit
// ST_BRK    | break seen, waiting for OVS high ticks
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_type,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic [2:0]        rx_err,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_busy,
    output logic              rx_overrun,
    output logic              rx_break
);

    localparam int PH_W = $clog2(OVS);
    localparam int BC_W = $clog2(DATA_W);

    logic              rxd_s1_q, rxd_s1_d, rxd_s2_q, rxd_s2_d, rxd_s3_q, rxd_s3_d;
    rx_state_e         state_q, state_d;
    logic [1:0]        par_type_q, par_type_d;
    logic              stop2_q, stop2_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [1:0]        smp_q, smp_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_acc_q, par_acc_d;
    logic              perr_q, perr_d, ferr_q, ferr_d, glitch_q, glitch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        err_q, err_d;
    logic              valid_q, valid_d, ovr_q, ovr_d;
`ifdef UART_RX_BREAK_EN
    logic              brk_q, brk_d, par_bit_q, par_bit_d;
    logic [PH_W-1:0]   hi_q, hi_d;
`endif

    logic tick, start_det, eval, maj, par_en, complete, ferr_now;

    assign start_det = (state_q == ST_IDLE) && rxd_s3_q && !rxd_s2_q;
    assign par_en    = (par_type_q == PAR_ODD) || (par_type_q == PAR_EVEN);
    assign eval      = tick && (ph_q == PH_W'(OVS/2));
    assign maj       = maj3(smp_q[0], smp_q[1], rxd_s2_q);

    uart_rx_tick #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_det),
        .div  (div_q),
        .tick (tick)
    );

    // Next-state, datapath and holding-register logic.
    always_comb begin
        rxd_s1_d   = rxd;
        rxd_s2_d   = rxd_s1_q;
        rxd_s3_d   = rxd_s2_q;
        state_d    = state_q;
        par_type_d = par_type_q;
        stop2_d    = stop2_q;
        div_d      = div_q;
        ph_d       = ph_q;
        smp_d      = smp_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        par_acc_d  = par_acc_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        glitch_d   = glitch_q;
        data_d     = data_q;
        err_d      = err_q;
        valid_d    = valid_q;
        ovr_d      = 1'b0;
        complete   = 1'b0;
        ferr_now   = ferr_q;
`ifdef UART_RX_BREAK_EN
        brk_d      = 1'b0;
        par_bit_d  = par_bit_q;
        hi_d       = hi_q;
`endif

        // Bit-phase counter and the two early majority samples.
        if (start_det) begin
            ph_d = '0;
        end else if (tick) begin
            ph_d = (ph_q == PH_W'(OVS-1)) ? '0 : ph_q + PH_W'(1);
            if (ph_q == PH_W'(OVS/2-2)) smp_d[0] = rxd_s2_q;
            if (ph_q == PH_W'(OVS/2-1)) smp_d[1] = rxd_s2_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    state_d    = ST_START;
                    par_type_d = parity_type;
                    stop2_d    = stop2;
                    div_d      = baud_div;
                    bit_d      = '0;
                    par_acc_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            ST_START: begin
                if (eval) begin
                    if (maj) begin
                        glitch_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (eval) begin
                    sh_d      = {maj, sh_q[DATA_W-1:1]};
                    par_acc_d = par_acc_q ^ maj;
                    if (bit_q == BC_W'(DATA_W-1)) begin
                        state_d = par_en ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (eval) begin
                    perr_d  = (par_type_q == PAR_ODD) ? !(par_acc_q ^ maj) : (par_acc_q ^ maj);
`ifdef UART_RX_BREAK_EN
                    par_bit_d = maj;
`endif
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (eval) begin
                    ferr_now = ferr_q | !maj;
                    ferr_d   = ferr_now;
`ifdef UART_RX_BREAK_EN
                    if (!maj && (sh_q == '0) && (!par_en || !par_bit_q)) begin
                        brk_d   = 1'b1;
                        hi_d    = '0;
                        state_d = ST_BRK;
                    end else
`endif
                    if (stop2_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (eval) begin
                    ferr_now = ferr_q | !maj;
                    ferr_d   = ferr_now;
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
`ifdef UART_RX_BREAK_EN
            ST_BRK: begin
                if (tick) begin
                    if (!rxd_s2_q) begin
                        hi_d = '0;
                    end else if (hi_q == PH_W'(OVS-1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        hi_d = hi_q + PH_W'(1);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Holding register: consumer transfer, then frame load or overrun.
        if (valid_q && rx_ready) valid_d = 1'b0;
        if (complete) begin
            if (!valid_q || rx_ready) begin
                data_d             = sh_q;
                err_d              = '0;
                err_d[ERR_PARITY]  = perr_q;
                err_d[ERR_GLITCH]  = glitch_q;
                err_d[ERR_FRAME]   = ferr_now;
                valid_d            = 1'b1;
                glitch_d           = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_s3_q   <= 1'b1;
            state_q    <= ST_IDLE;
            par_type_q <= PAR_NONE;
            stop2_q    <= 1'b0;
            div_q      <= '0;
            ph_q       <= '0;
            smp_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            glitch_q   <= 1'b0;
            data_q     <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_EN
            brk_q      <= 1'b0;
            par_bit_q  <= 1'b0;
            hi_q       <= '0;
`endif
        end else begin
            rxd_s1_q   <= rxd_s1_d;
            rxd_s2_q   <= rxd_s2_d;
            rxd_s3_q   <= rxd_s3_d;
            state_q    <= state_d;
            par_type_q <= par_type_d;
            stop2_q    <= stop2_d;
            div_q      <= div_d;
            ph_q       <= ph_d;
            smp_q      <= smp_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            par_acc_q  <= par_acc_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            glitch_q   <= glitch_d;
            data_q     <= data_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_EN
            brk_q      <= brk_d;
            par_bit_q  <= par_bit_d;
            hi_q       <= hi_d;
`endif
        end
    end

    assign rx_data    = data_q;
    assign rx_err     = err_q;
    assign rx_valid   = valid_q;
    assign rx_busy    = (state_q != ST_IDLE);
    assign rx_overrun = ovr_q;
`ifdef UART_RX_BREAK_EN
    assign rx_break   = brk_q;
`else
    assign rx_break   = 1'b0;
`endif

endmodule
